id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode stage directly downstream of the fetch stage (yIF).
- Latches the fetch outputs (ins, PCp4) into an IF/ID pipeline register with a valid/stall/flush handshake.
- Reads two operands from a 32x32 register file and produces the extended immediate and jump target for the execute stage (yAlu).
- Accepts a single write-back port from the final stage.

Parameters:
- WIDTH, 32, datapath width (instruction, PC, register data)
- NREG, 32, number of architectural registers (5-bit index)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  fetch presents a valid instruction this cycle
- in_ready  output  1  ID stage accepts fetch data this cycle; equals ~stall
- ins  input  32  instruction from fetch
- pcp4  input  32  PC+4 from fetch
- stall  input  1  hazard unit: hold IF/ID contents
- flush  input  1  branch/jump taken: squash IF/ID contents
- wb_en  input  1  register-file write enable
- wb_addr  input  5  write-back register index
- wb_data  input  32  write-back data
- out_valid  output  1  latched instruction is valid
- out_ins  output  32  latched instruction
- out_pcp4  output  32  latched PC+4
- rs, rt, rd  output  5 each  out_ins[25:21], [20:16], [15:11]
- rd1  output  32  register[rs]
- rd2  output  32  register[rt]
- imm  output  32  extended out_ins[15:0]
- jtarget  output  32  {out_pcp4[31:28], out_ins[25:0], 2'b00}

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_ins=0, out_pcp4=0.
  - All register-file entries cleared to 0.
  - Applies immediately and holds while rst=1.
  - Reset mid-stall or mid-write discards the pending operation.
- IF/ID latch, at posedge clk, priority flush > stall > load:
  - flush=1: out_valid<=0, out_ins<=0 (a NOP). out_pcp4 unchanged.
  - flush=0, stall=1: all latch contents held.
  - Otherwise: out_valid<=in_valid, out_ins<=ins, out_pcp4<=pcp4.
- Latency: fetch data appears on the out_* ports one cycle after acceptance.
- in_ready is combinational, equal to ~stall. It is independent of flush, so a flushed cycle still consumes the fetch slot.
- Register file:
  - Write occurs at posedge clk when wb_en=1 and wb_addr!=0.
  - Writes to register 0 are ignored; register 0 always reads 0.
  - Writes proceed regardless of stall and flush.
- Read ports are combinational from rs/rt.
- Write-through bypass: if wb_en=1 and wb_addr==rs!=0, then rd1=wb_data in the same cycle. rd2 uses the same rule with rt.
- Immediate:
  - Opcode out_ins[31:26] = 0x0C (andi) or 0x0D (ori): zero-extend.
  - All other opcodes: sign-extend.
- out_valid=0 does not gate rd1/rd2/imm. Downstream qualifies them with out_valid.
- Stall and write-back in the same cycle: the latch holds and the write occurs. The next read of that register returns the new value.

Decomposition:
- Shared package: opcode constants (OP_RTYPE=0x00, OP_LW=0x23, OP_SW=0x2B, OP_BEQ=0x04, OP_J=0x02, OP_ANDI=0x0C, OP_ORI=0x0D) and the field bit positions for rs/rt/rd/imm/target.
- One sub-module: regfile_32x32 (2 read ports, 1 write port, register-0 hardwiring, async clear, bypass).
- IF/ID latch and immediate logic stay in id_stage.

Test Plan:
- Reset then load: rst pulse, then in_valid=1, ins=0x8C080004, pcp4=0x2C at one edge -> next cycle out_valid=1, out_ins=0x8C080004, rs=0, rt=8, imm=0x00000004.
- Write/read: wb_en=1, wb_addr=8, wb_data=0xDEADBEEF at an edge; then ins=0x01095020 (add $10,$8,$9) latched -> rd1=0xDEADBEEF, rd2=0. Writing wb_addr=0 with 0x1234 -> a later read of reg 0 returns 0.
- Bypass: wb_en=1, wb_addr=9, wb_data=0x55 while the latched ins has rt=9 -> rd2=0x55 combinationally, before the edge.
- Immediate: ins=0x2108FFFF (addi) -> imm=0xFFFFFFFF. ins=0x3508FFFF (ori) -> imm=0x0000FFFF. ins=0x0800000A with pcp4=0x30 -> jtarget=0x00000028.
- Stall/flush: stall=1 for 2 cycles with changing ins -> out_ins and out_valid held, in_ready=0. Asserting stall=1 and flush=1 together -> out_valid=0, out_ins=0.
- Async reset mid-run: after writing reg 8=0x77, rst=1 between clock edges -> out_valid=0 immediately, and reg 8 reads 0 after release.

Source files
------------

// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - opcodes, instruction field positions and immediate helper for the decode stage
package id_stage_pkg;

  localparam int REG_AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int TGT_MSB = 25;
  localparam int TGT_LSB = 0;

  // Logical immediates are zero-extended; everything else is sign-extended.
  function automatic logic is_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/regfile_32x32.sv
// rtl/regfile_32x32.sv - 2-read/1-write register file with r0 hardwired to zero and write-through bypass
module regfile_32x32
  import id_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1_i,
  input  logic [REG_AW-1:0] ra2_i,
  output logic [WIDTH-1:0]  rd1_o,
  output logic [WIDTH-1:0]  rd2_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [WIDTH-1:0]  wd_i
);

  logic [WIDTH-1:0] regs_q [NREG];
  logic             wr_act;

  assign wr_act = we_i && (wa_i != '0);

  // Storage: async clear on reset, r0 is never written so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_act) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Combinational reads; a same-cycle write to the addressed register is forwarded.
  always_comb begin
    rd1_o = regs_q[ra1_i];
    rd2_o = regs_q[ra2_i];
    if (ra1_i == '0) begin
      rd1_o = '0;
    end else if (wr_act && (wa_i == ra1_i)) begin
      rd1_o = wd_i;
    end
    if (ra2_i == '0) begin
      rd2_o = '0;
    end else if (wr_act && (wa_i == ra2_i)) begin
      rd2_o = wd_i;
    end
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - IF/ID pipeline latch, operand read, immediate extension and jump target
module id_stage
  import id_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  ins,
  input  logic [WIDTH-1:0]  pcp4,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_ins,
  output logic [WIDTH-1:0]  out_pcp4,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt,
  output logic [REG_AW-1:0] rd,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  output logic [WIDTH-1:0]  imm,
  output logic [WIDTH-1:0]  jtarget
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] ins_q, ins_d;
  logic [WIDTH-1:0] pcp4_q, pcp4_d;

  // A flushed cycle still consumes the fetch slot, so ready only depends on stall.
  assign in_ready = ~stall;

  // Latch next-state: flush inserts a NOP (PC+4 kept), stall holds, otherwise load.
  always_comb begin
    valid_d = valid_q;
    ins_d   = ins_q;
    pcp4_d  = pcp4_q;
    if (flush) begin
      valid_d = 1'b0;
      ins_d   = '0;
    end else if (!stall) begin
      valid_d = in_valid;
      ins_d   = ins;
      pcp4_d  = pcp4;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ins_q   <= '0;
      pcp4_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ins_q   <= ins_d;
      pcp4_q  <= pcp4_d;
    end
  end

  assign out_valid = valid_q;
  assign out_ins   = ins_q;
  assign out_pcp4  = pcp4_q;

  assign rs = ins_q[RS_MSB:RS_LSB];
  assign rt = ins_q[RT_MSB:RT_LSB];
  assign rd = ins_q[RD_MSB:RD_LSB];

  // Immediate extension is not gated by valid; execute qualifies with out_valid.
  always_comb begin
    imm = {{(WIDTH-16){ins_q[IMM_MSB]}}, ins_q[IMM_MSB:IMM_LSB]};
    if (is_zero_ext(ins_q[OP_MSB:OP_LSB])) begin
      imm = {{(WIDTH-16){1'b0}}, ins_q[IMM_MSB:IMM_LSB]};
    end
  end

  assign jtarget = {pcp4_q[WIDTH-1:WIDTH-4], ins_q[TGT_MSB:TGT_LSB], 2'b00};

  regfile_32x32 #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (rs),
    .ra2_i (rt),
    .rd1_o (rd1),
    .rd2_o (rd2),
    .we_i  (wb_en),
    .wa_i  (wb_addr),
    .wd_i  (wb_data)
  );

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ins;
  logic [31:0] pcp4;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic [31:0] out_ins;
  logic [31:0] out_pcp4;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm;
  logic [31:0] jtarget;

  id_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ins       (ins),
    .pcp4      (pcp4),
    .stall     (stall),
    .flush     (flush),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ins   (out_ins),
    .out_pcp4  (out_pcp4),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .rd1       (rd1),
    .rd2       (rd2),
    .imm       (imm),
    .jtarget   (jtarget)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic [31:0] pcp4;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_ins;
  logic [31:0] m_pcp4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_imm(input logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    if (op == 6'h0C || op == 6'h0D) return {16'h0000, i[15:0]};
    return {{16{i[15]}}, i[15:0]};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_valid = 1'b0;
    m_ins   = 32'h0;
    m_pcp4  = 32'h0;
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk("out_valid", {31'b0, out_valid}, {31'b0, e.v});
    chk("out_ins", out_ins, e.ins);
    chk("out_pcp4", out_pcp4, e.pcp4);
    chk("rs", {27'b0, rs}, {27'b0, e.ins[25:21]});
    chk("rt", {27'b0, rt}, {27'b0, e.ins[20:16]});
    chk("rd", {27'b0, rd}, {27'b0, e.ins[15:11]});
    chk("imm", imm, m_imm(e.ins));
    chk("jtarget", jtarget, {e.pcp4[31:28], e.ins[25:0], 2'b00});
    chk("rd1_post", rd1, m_read(e.ins[25:21], 1'b0, 5'd0, 32'h0));
    chk("rd2_post", rd2, m_read(e.ins[20:16], 1'b0, 5'd0, 32'h0));
  endtask

  // Starts and ends at a negedge; checks comb outputs before the edge, latch after it.
  task automatic cycle(input logic v, input logic [31:0] i_ins, input logic [31:0] i_pc,
                       input logic s, input logic f, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    in_valid = v; ins = i_ins; pcp4 = i_pc; stall = s; flush = f;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    chk("in_ready", {31'b0, in_ready}, {31'b0, !s});
    chk("rd1_pre", rd1, m_read(m_ins[25:21], we, wa, wd));
    chk("rd2_pre", rd2, m_read(m_ins[20:16], we, wa, wd));
    @(posedge clk);
    if (we && wa != 5'd0) m_regs[wa] = wd;
    if (f) begin
      m_valid = 1'b0;
      m_ins   = 32'h0;
    end else if (!s) begin
      m_valid = v;
      m_ins   = i_ins;
      m_pcp4  = i_pc;
    end
    e.v = m_valid; e.ins = m_ins; e.pcp4 = m_pcp4;
    sb_q.push_back(e);
    #1;
    wb_en = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    #1;
    compare_out();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ins = 32'h0; pcp4 = 32'h0;
    stall = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ins", out_ins, 32'h0);
    chk("rst_pcp4", out_pcp4, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Reset then load
    cycle(1'b1, 32'h8C080004, 32'h0000002C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("tp_load_valid", {31'b0, out_valid}, 32'd1);
    chk("tp_load_ins", out_ins, 32'h8C080004);
    chk("tp_load_rt", {27'b0, rt}, 32'd8);
    chk("tp_load_imm", imm, 32'h00000004);

    // Write then read
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd8, 32'hDEADBEEF);
    cycle(1'b1, 32'h01095020, 32'h00000030, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("tp_rd1", rd1, 32'hDEADBEEF);
    chk("tp_rd2", rd2, 32'h0);

    // Bypass: rt=9 latched, hold latch while writing r9
    in_valid = 1'b0; stall = 1'b1; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
    #1;
    chk("tp_bypass", rd2, 32'h00000055);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h55);
    chk("tp_after_wr", rd2, 32'h00000055);

    // r0 writes are dropped
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1234);
    cycle(1'b1, 32'h00095020, 32'h00000040, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("tp_r0", rd1, 32'h0);

    // Immediates and jump target
    cycle(1'b1, 32'h2108FFFF, 32'h00000044, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("tp_addi", imm, 32'hFFFFFFFF);
    cycle(1'b1, 32'h3508FFFF, 32'h00000048, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("tp_ori", imm, 32'h0000FFFF);
    cycle(1'b1, 32'h3108F000, 32'h0000004C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("tp_andi", imm, 32'h0000F000);
    cycle(1'b1, 32'h0800000A, 32'h00000030, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("tp_jtarget", jtarget, 32'h00000028);
    cycle(1'b1, 32'h0BFFFFFF, 32'hF0000004, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("tp_jtarget_hi", jtarget, 32'hFFFFFFFC);

    // Stall two cycles with changing fetch data, write-back still lands
    cycle(1'b0, 32'h11111111, 32'h00000050, 1'b1, 1'b0, 1'b1, 5'd12, 32'hCAFE0001);
    cycle(1'b1, 32'h22222222, 32'h00000054, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("tp_stall_ins", out_ins, 32'h0BFFFFFF);
    chk("tp_stall_valid", {31'b0, out_valid}, 32'd1);
    cycle(1'b1, 32'h018B5020, 32'h00000058, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("tp_stall_wr", rd1, 32'hCAFE0001);

    // Flush wins over stall; pcp4 kept
    cycle(1'b1, 32'h33333333, 32'h0000005C, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    chk("tp_flush_valid", {31'b0, out_valid}, 32'd0);
    chk("tp_flush_ins", out_ins, 32'h0);
    chk("tp_flush_pcp4", out_pcp4, 32'h00000058);

    // A handful of random cycles through the scoreboard
    for (int k = 0; k < 40; k++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end

    // Async reset mid-run
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h77);
    cycle(1'b1, 32'h01095020, 32'h00000060, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("tp_pre_rst_rd1", rd1, 32'h00000077);
    #2;
    rst = 1'b1;
    #1;
    chk("tp_arst_valid", {31'b0, out_valid}, 32'd0);
    chk("tp_arst_ins", out_ins, 32'h0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 32'h01095020, 32'h00000064, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("tp_arst_r8", rd1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
